imm_decode_stage: RTL

//  Registered immediate-decode stage between fetch and decode.
//  - Classifies the instruction format from the opcode itself; no one-hot format input.
//  - Builds the sign-extended immediate at XLEN width.
//  - Passes the instruction and a sidecar tag through a 2-entry skid buffer with valid/ready on both sides.
//  - Latency is 1 cycle. Full throughput is 1 instruction per cycle under no backpressure.

---
 rtl/imm_decode_stage_if.sv | 29 ++
 rtl/imm_decode_stage.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage_if.sv
// Handshake and data bundle for imm_decode_stage.
// slave  : the view taken by the stage itself.
// master : the view taken by the surrounding fetch/decode logic.
interface imm_decode_stage_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             i_valid;
  logic             o_ready;
  logic [31:0]      i_inst;
  logic [TAG_W-1:0] i_tag;
  logic             o_valid;
  logic             i_ready;
  logic [XLEN-1:0]  o_immediate;
  logic [5:0]       o_format;
  logic             o_illegal;
  logic [31:0]      o_inst;
  logic [TAG_W-1:0] o_tag;

  modport slave (
    input  i_valid, i_inst, i_tag, i_ready,
    output o_ready, o_valid, o_immediate, o_format, o_illegal, o_inst, o_tag
  );

  modport master (
    output i_valid, i_inst, i_tag, i_ready,
    input  o_ready, o_valid, o_immediate, o_format, o_illegal, o_inst, o_tag
  );
endinterface

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage between fetch and decode.
// Decodes format and sign-extended immediate from the opcode, then carries
// the decoded beat through a 2-entry skid buffer (main + skid).
// Optional feature: define IMM_CSR_EN to give CSR*I instructions their
// zero-extended uimm (inst[19:15]) as the immediate.
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input logic          i_clk,
  input logic          i_rst_n,
  imm_decode_stage_if.slave bus
);

  typedef enum logic [5:0] {
    FMT_NONE = 6'b000000,
    FMT_R    = 6'b000001,
    FMT_I    = 6'b000010,
    FMT_S    = 6'b000100,
    FMT_B    = 6'b001000,
    FMT_U    = 6'b010000,
    FMT_J    = 6'b100000
  } fmt_e;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM_32   = 7'b0011011;
  localparam logic [6:0] OP_OP_32    = 7'b0111011;

  logic [31:0]        inst;
  fmt_e               dec_fmt;
  logic signed [31:0] dec_imm32;
  logic [XLEN-1:0]    dec_imm;
  logic               dec_ill;

  logic               main_valid;
  logic [31:0]        main_inst;
  logic [TAG_W-1:0]   main_tag;
  logic [XLEN-1:0]    main_imm;
  fmt_e               main_fmt;
  logic               main_ill;

  logic               skid_valid;
  logic [31:0]        skid_inst;
  logic [TAG_W-1:0]   skid_tag;
  logic [XLEN-1:0]    skid_imm;
  fmt_e               skid_fmt;
  logic               skid_ill;

  logic               accept;
  logic               consume;
  logic               main_free;

  assign inst = bus.i_inst;

  // Classify the format from the opcode and assemble the 32-bit immediate.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    dec_fmt   = FMT_NONE;
    dec_imm32 = '0;
    case (inst[6:0])
      OP_LUI, OP_AUIPC:                               dec_fmt = FMT_U;
      OP_JAL:                                         dec_fmt = FMT_J;
      OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM, OP_MISC_MEM: dec_fmt = FMT_I;
      OP_STORE:                                       dec_fmt = FMT_S;
      OP_BRANCH:                                      dec_fmt = FMT_B;
      OP_OP:                                          dec_fmt = FMT_R;
      OP_IMM_32:                                      dec_fmt = (XLEN == 64) ? FMT_I : FMT_NONE;
      OP_OP_32:                                       dec_fmt = (XLEN == 64) ? FMT_R : FMT_NONE;
      default:                                        dec_fmt = FMT_NONE;
    endcase
    case (dec_fmt)
      FMT_I:   dec_imm32 = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   dec_imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   dec_imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   dec_imm32 = {inst[31:12], 12'b0};
      FMT_J:   dec_imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: dec_imm32 = '0;
    endcase
`ifdef IMM_CSR_EN
    if (inst[6:0] == OP_SYSTEM && inst[14]) begin
      dec_imm32 = {27'b0, inst[19:15]};
    end
`endif
    // Signed size cast replicates bit 31 up to XLEN.
    dec_imm = XLEN'(dec_imm32);
    dec_ill = (dec_fmt == FMT_NONE);
  end

  // o_ready depends only on registered state (and reset), never on i_ready.
  assign bus.o_ready = i_rst_n & ~skid_valid;
  assign accept      = bus.i_valid & bus.o_ready;
  assign consume     = main_valid & bus.i_ready;
  assign main_free   = ~main_valid | consume;

  // Main entry and both valid flags: refill main from skid first, else from input.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_inst  <= '0;
      main_tag   <= '0;
      main_imm   <= '0;
      main_fmt   <= FMT_NONE;
      main_ill   <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
        main_inst  <= skid_inst;
        main_tag   <= skid_tag;
        main_imm   <= skid_imm;
        main_fmt   <= skid_fmt;
        main_ill   <= skid_ill;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_inst  <= inst;
        main_tag   <= bus.i_tag;
        main_imm   <= dec_imm;
        main_fmt   <= dec_fmt;
        main_ill   <= dec_ill;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
    end
  end

  // Skid payload captures a beat accepted while main is stalled.
  always_ff @(posedge i_clk) begin
    // NOTE: the skid payload has no reset; it is only ever read while skid_valid is set.
    if (accept && !main_free) begin
      skid_inst <= inst;
      skid_tag  <= bus.i_tag;
      skid_imm  <= dec_imm;
      skid_fmt  <= dec_fmt;
      skid_ill  <= dec_ill;
    end
  end

  assign bus.o_valid     = main_valid;
  assign bus.o_inst      = main_inst;
  assign bus.o_tag       = main_tag;
  assign bus.o_immediate = main_imm;
  assign bus.o_format    = main_fmt;
  assign bus.o_illegal   = main_ill;

endmodule
